subservient_uart_loader: RTL and testbench

Boot-time firmware loader upstream of the subservient SoC's byte-wide SRAM write port. Receives one framed firmware image over a UART RX line and writes it into SRAM starting at address 0. Holds the core in reset until a frame with a valid checksum has been written. Hardware replacement for $readmemh preloading on FPGA targets.

---
 rtl/subservient_uart_loader.sv | 187 ++++++++++++++++++
 tb/tb_subservient_uart_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/subservient_uart_loader.sv
// Boot-time firmware loader: receives a framed image over UART (8N1) and writes it
// into SRAM from address 0, holding the core in reset until the checksum matches.
module subservient_uart_loader #(
  parameter int memsize      = 512,
  parameter int aw           = $clog2(memsize),
  parameter int CLKS_PER_BIT = 139
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rx,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic          o_core_rst,
  output logic          o_done,
  output logic          o_err
);

  localparam int            CW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]   MAXLEN = 17'(memsize);
  localparam logic [7:0]    SYNC   = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {F_SYNC, F_LEN_LO, F_LEN_HI, F_DATA, F_CSUM, F_DONE, F_ERR} fr_state_t;

  logic          rx_meta, rx_sync;
  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] tick, tick_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          rx_valid, rx_valid_nx, rx_ferr, rx_ferr_nx;

  fr_state_t     fr_state, fr_nx;
  logic [15:0]   cnt, cnt_nx, cnt_inc, len, len_nx, len_full;
  logic [7:0]    csum, csum_nx;
  logic [aw-1:0] waddr_nx;
  logic [7:0]    wdata_nx;
  logic          wen_nx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_state     <= R_IDLE;
      tick         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_valid     <= 1'b0;
      rx_ferr      <= 1'b0;
      fr_state     <= F_SYNC;
      cnt          <= '0;
      len          <= '0;
      csum         <= '0;
      o_sram_waddr <= '0;
      o_sram_wdata <= '0;
      o_sram_wen   <= 1'b0;
      o_core_rst   <= 1'b1;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      rx_meta      <= i_rx;
      rx_sync      <= rx_meta;
      rx_state     <= rx_state_nx;
      tick         <= tick_nx;
      bit_idx      <= bit_idx_nx;
      shreg        <= shreg_nx;
      rx_valid     <= rx_valid_nx;
      rx_ferr      <= rx_ferr_nx;
      fr_state     <= fr_nx;
      cnt          <= cnt_nx;
      len          <= len_nx;
      csum         <= csum_nx;
      o_sram_waddr <= waddr_nx;
      o_sram_wdata <= wdata_nx;
      o_sram_wen   <= wen_nx;
      o_core_rst   <= (fr_nx != F_DONE);
      o_done       <= (fr_nx == F_DONE);
      o_err        <= (fr_nx == F_ERR);
    end
  end

  // UART receiver: start bit re-checked at mid-bit, data/stop sampled a full bit apart
  always_comb begin
    rx_state_nx = rx_state;
    tick_nx     = tick;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    rx_valid_nx = 1'b0;
    rx_ferr_nx  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (!rx_sync) begin
          rx_state_nx = R_START;
          tick_nx     = '0;
        end
      end
      R_START: begin
        if (tick == HALF) begin
          tick_nx     = '0;
          bit_idx_nx  = '0;
          rx_state_nx = rx_sync ? R_IDLE : R_DATA;
        end else begin
          tick_nx = tick + CW'(1);
        end
      end
      R_DATA: begin
        if (tick == FULL) begin
          tick_nx  = '0;
          shreg_nx = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) rx_state_nx = R_STOP;
          else bit_idx_nx = bit_idx + 3'd1;
        end else begin
          tick_nx = tick + CW'(1);
        end
      end
      R_STOP: begin
        if (tick == FULL) begin
          tick_nx     = '0;
          rx_valid_nx = rx_sync;
          rx_ferr_nx  = !rx_sync;
          rx_state_nx = R_IDLE;
        end else begin
          tick_nx = tick + CW'(1);
        end
      end
      default: rx_state_nx = R_IDLE;
    endcase
  end

  // Frame parser; shreg still holds the received byte while rx_valid is high
  always_comb begin
    fr_nx    = fr_state;
    cnt_nx   = cnt;
    cnt_inc  = cnt + 16'd1;
    len_nx   = len;
    len_full = {shreg, len[7:0]};
    csum_nx  = csum;
    waddr_nx = o_sram_waddr;
    wdata_nx = o_sram_wdata;
    wen_nx   = 1'b0;
    case (fr_state)
      F_SYNC, F_ERR: begin
        if (rx_valid && shreg == SYNC) begin
          fr_nx   = F_LEN_LO;
          cnt_nx  = '0;
          csum_nx = '0;
        end
      end
      F_LEN_LO: begin
        if (rx_ferr) fr_nx = F_ERR;
        else if (rx_valid) begin
          len_nx[7:0] = shreg;
          fr_nx       = F_LEN_HI;
        end
      end
      F_LEN_HI: begin
        if (rx_ferr) fr_nx = F_ERR;
        else if (rx_valid) begin
          len_nx = len_full;
          if ({1'b0, len_full} > MAXLEN) fr_nx = F_ERR;
          else if (len_full == '0)       fr_nx = F_CSUM;
          else                           fr_nx = F_DATA;
        end
      end
      F_DATA: begin
        if (rx_ferr) fr_nx = F_ERR;
        else if (rx_valid) begin
          wen_nx   = 1'b1;
          waddr_nx = cnt[aw-1:0];
          wdata_nx = shreg;
          cnt_nx   = cnt_inc;
          csum_nx  = csum + shreg;
          if (cnt_inc == len) fr_nx = F_CSUM;
        end
      end
      F_CSUM: begin
        if (rx_ferr) fr_nx = F_ERR;
        else if (rx_valid) fr_nx = (shreg == csum) ? F_DONE : F_ERR;
      end
      F_DONE: fr_nx = F_DONE;
      default: fr_nx = F_SYNC;
    endcase
  end

endmodule

// File: tb/tb_subservient_uart_loader.sv
// Bench for subservient_uart_loader: directed frames plus random frames checked
// against a frame-level model (expected writes list, done/err flags).
module tb_subservient_uart_loader;

  localparam int MEMSIZE = 512;
  localparam int AW      = 9;
  localparam int CPB     = 8;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_rx;
  logic [AW-1:0] o_sram_waddr;
  logic [7:0]    o_sram_wdata;
  logic          o_sram_wen, o_core_rst, o_done, o_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] obs_w[$];
  logic [31:0] exp_w[$];
  bit          exp_done, exp_err;

  subservient_uart_loader #(.memsize(MEMSIZE), .CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_rx(i_rx),
    .o_sram_waddr(o_sram_waddr), .o_sram_wdata(o_sram_wdata), .o_sram_wen(o_sram_wen),
    .o_core_rst(o_core_rst), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (o_sram_wen) obs_w.push_back({15'b0, o_sram_waddr, o_sram_wdata});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({o_sram_waddr, o_sram_wdata, o_sram_wen, o_core_rst, o_done, o_err});
  endfunction

  task automatic model_clear();
    obs_w.delete();
    exp_w.delete();
    exp_done = 0;
    exp_err  = 0;
  endtask

  task automatic do_reset();
    i_rx = 1'b1;
    #2 i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    check("rst_state", outs(), 32'h4);
    model_clear();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1. rst_after>=0 pulses reset mid-byte and aborts it.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int rst_after);
    logic [9:0] frame;
    int clks = 0;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx = frame[i];
      for (int c = 0; c < CPB; c++) begin
        @(posedge clk);
        clks++;
        if (rst_after >= 0 && clks == rst_after) begin
          #2 i_rst = 1'b1;
          #1 check("async_rst", outs(), 32'h4);
          #1 i_rst = 1'b0;
          i_rx = 1'b1;
          return;
        end
        #1;
      end
    end
    i_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame and advances the model. Bytes below nfix come from fixed.
  task automatic send_frame(input int n, input logic [7:0] mask,
                            input logic [63:0] fixed, input int nfix);
    logic [15:0] n16;
    logic [7:0]  d[$];
    logic [7:0]  b, sum;
    bit          active;
    n16    = 16'(n);
    sum    = 8'h00;
    active = !exp_done;
    send_byte(8'hA5, 1'b1, -1);
    if (active && exp_err) begin
      idle(2);
      check("err_clear", 32'(o_err), 32'h0);
      exp_err = 0;
    end
    send_byte(n16[7:0], 1'b1, -1);
    send_byte(n16[15:8], 1'b1, -1);
    if (n > MEMSIZE) begin
      if (active) exp_err = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      b = (i < nfix) ? fixed[8*i +: 8] : 8'($urandom_range(0, 255));
      d.push_back(b);
      sum = sum + b;
      send_byte(b, 1'b1, -1);
    end
    if (active) check("no_early_done", 32'(o_done), 32'h0);
    send_byte(sum ^ mask, 1'b1, -1);
    if (active) begin
      for (int i = 0; i < n; i++) exp_w.push_back({15'b0, 9'(i), d[i]});
      exp_done = (mask == 8'h00);
      exp_err  = (mask != 8'h00);
    end
  endtask

  task automatic verify(input string tag);
    idle(12);
    @(negedge clk);
    check({tag, "_nwr"}, 32'(obs_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      check({tag, "_wr"}, obs_w[i], exp_w[i]);
    check({tag, "_done"}, 32'(o_done), 32'(exp_done));
    check({tag, "_err"}, 32'(o_err), 32'(exp_err));
    check({tag, "_crst"}, 32'(o_core_rst), 32'(!exp_done));
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    i_rx  = 1'b1;
    #1;
    check("rst_t0", outs(), 32'h4);

    do_reset();
    send_frame(4, 8'h00, 64'h44332211, 4);
    verify("basic");

    do_reset();
    send_frame(2, 8'h30, 64'h2010, 2);
    verify("badsum");
    send_frame(1, 8'h00, 64'h7F, 1);
    verify("recover");

    do_reset();
    send_frame(513, 8'h00, 64'h0, 0);
    verify("oversize");
    send_frame(0, 8'h00, 64'h0, 0);
    verify("empty");

    do_reset();
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'hFF, 1'b1, -1);
    send_byte(8'h3C, 1'b1, -1);
    i_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 idle(20);
    verify("garbage");
    send_frame(1, 8'h00, 64'h55, 1);
    verify("after_garbage");

    do_reset();
    send_byte(8'hA5, 1'b1, -1);
    send_byte(8'h03, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'h01, 1'b1, -1);
    send_byte(8'h02, 1'b0, -1);
    exp_w.push_back({15'b0, 9'd0, 8'h01});
    exp_err = 1;
    verify("ferr");

    do_reset();
    send_byte(8'hA5, 1'b1, -1);
    send_byte(8'h03, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'h01, 1'b1, -1);
    send_byte(8'h02, 1'b1, 30);
    #1 check("pre_rst_nwr", 32'(obs_w.size()), 32'd1);
    model_clear();
    idle(20);
    send_frame(2, 8'h00, 64'h0A09, 2);
    verify("post_rst");

    for (int it = 0; it < 8; it++) begin
      int nframes;
      do_reset();
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        logic [7:0] gb;
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) gb = 8'h00;
        send_byte(gb, 1'b1, -1);
      end
      nframes = $urandom_range(1, 3);
      for (int f = 0; f < nframes; f++) begin
        if ($urandom_range(0, 7) == 0)
          send_frame(MEMSIZE + 1 + $urandom_range(0, 1000), 8'h00, 64'h0, 0);
        else
          send_frame($urandom_range(0, 10),
                     ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                     64'h0, 0);
      end
      verify("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
